pipe_seg_adder: RTL

- Parametrised, pipelined adder/subtractor for the Gaussian FIR datapath.
- Splits a WIDTH-bit add into WIDTH/SEG ripple segments, each built from full-adder cells.
- Each segment has its own register stage, so the segment carry chain is registered between stages and timing stays bounded at wide widths.
- Valid/ready handshake with backpressure; feeds the kernel accumulation tree and the normalisation stage.

---
 rtl/pipe_seg_adder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_seg_adder.sv
// ---------------------------------------------------------------------------
// pipe_seg_adder
//
// Pipelined adder/subtractor for the Gaussian FIR datapath. A WIDTH-bit add
// is split into STAGES = WIDTH/SEG ripple segments. Each segment is built
// from full-adder cells and has its own register stage, so the carry
// between segments is registered.
//
// Operand segments that are not consumed yet travel forward through the
// stages (skew). Result segments that are already finished travel forward
// with them (deskew), so the whole sum emerges together. A final output
// register presents the result. From the accepting edge t, the result is
// visible after edge t+STAGES.
//
// The whole pipeline shares one advance enable:
//   adv = ~out_valid | out_ready
// There is no bubble compression.
//
// Parameters
//   WIDTH : operand/result width. Must be a multiple of SEG, and >= SEG.
//   SEG   : bits per pipeline segment.
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset; clears every register
//   in_valid  : a, b, cin, sub carry valid operands
//   in_ready  : operands are accepted this cycle (equals adv)
//   a, b      : operands
//   cin       : carry-in, ignored when sub=1
//   sub       : 0 -> a+b+cin, 1 -> a-b computed as a+~b+1
//   out_valid : sum/cout/ovf hold a valid result
//   out_ready : downstream accepts the result
//   sum       : result modulo 2^WIDTH
//   cout      : carry out of the MSB (not-borrow when sub=1)
//   ovf       : signed overflow, evaluated against the effective B operand
// ---------------------------------------------------------------------------
module pipe_seg_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  // One SEG-bit ripple segment of full-adder cells.
  // Returns {carry_out, partial_sum}.
  function automatic logic [SEG:0] seg_add(
    input logic [SEG-1:0] x,
    input logic [SEG-1:0] y,
    input logic           ci
  );
    logic [SEG-1:0] s;
    logic           c;
    c = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_bb;
  logic             w_c0;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;
  assign w_bb     = sub ? ~b : b;
  assign w_c0     = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still pending when entering stage k:
    // segments k..STAGES-1.
    localparam int IW = (STAGES - k) * SEG;

    logic [IW-1:0]          w_ia;
    logic [IW-1:0]          w_ib;
    logic                   w_ci;
    logic                   w_vi;
    logic [SEG:0]           w_add;
    logic [(k+1)*SEG-1:0]   w_sum_nx;

    logic                   r_vld;
    logic                   r_c;
    logic [(k+1)*SEG-1:0]   r_sum;

    if (k == 0) begin : g_src
      assign w_ia     = a;
      assign w_ib     = w_bb;
      assign w_ci     = w_c0;
      assign w_vi     = in_valid;
      assign w_sum_nx = w_add[SEG-1:0];
    end else begin : g_src
      assign w_ia     = g_stage[k-1].g_fwd.r_ua;
      assign w_ib     = g_stage[k-1].g_fwd.r_ub;
      assign w_ci     = g_stage[k-1].r_c;
      assign w_vi     = g_stage[k-1].r_vld;
      // Lower result segments ride along so all segments line up at the end.
      assign w_sum_nx = {w_add[SEG-1:0], g_stage[k-1].r_sum};
    end

    assign w_add = seg_add(w_ia[SEG-1:0], w_ib[SEG-1:0], w_ci);

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_vld <= w_vi;
        r_c   <= w_add[SEG];
        r_sum <= w_sum_nx;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Operand segments k+1.. are consumed by later stages.
      logic [IW-SEG-1:0] r_ua;
      logic [IW-SEG-1:0] r_ub;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ua <= '0;
          r_ub <= '0;
        end else if (w_adv) begin
          r_ua <= w_ia[IW-1:SEG];
          r_ub <= w_ib[IW-1:SEG];
        end
      end
    end else begin : g_last
      // The MSBs of a, bb and the sum are all local to the final segment.
      logic r_ovf;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= (w_ia[SEG-1] == w_ib[SEG-1]) && (w_add[SEG-1] != w_ia[SEG-1]);
        end
      end
    end
  end

  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_c;
  logic             r_out_ovf;

  // ---- output register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_sum <= '0;
      r_out_c   <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (w_adv) begin
      r_out_vld <= g_stage[STAGES-1].r_vld;
      r_out_sum <= g_stage[STAGES-1].r_sum;
      r_out_c   <= g_stage[STAGES-1].r_c;
      r_out_ovf <= g_stage[STAGES-1].g_last.r_ovf;
    end
  end

  assign out_valid = r_out_vld;
  assign sum       = r_out_sum;
  assign cout      = r_out_c;
  assign ovf       = r_out_ovf;

endmodule
